ext_mem_ctrl: RTL and testbench
===============================

# ext_mem_ctrl

Parametrised multi-port controller for the external program/data memory that the `cpu` core currently reads as a flat array. It owns a `2**ADDR_W` × `DATA_W` storage array and arbitrates up to `NUM_PORTS` requesters (port 0 = instruction fetch, port 1 = load/store) with round-robin fairness. Every requester uses a valid/ready handshake, and reads return after a configurable `READ_LAT`. A priority preload port lets benches and boot logic write program and data words directly into storage.

## Interface
- `DATA_W`, 64, word width; matches the 64-bit instruction/data word.
- `ADDR_W`, 8, address width; depth is `2**ADDR_W` words.
- `NUM_PORTS`, 2, number of requesters; legal range 1..8.
- `READ_LAT`, 1, cycles from read handshake to `rsp_valid`; legal range 1..4.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_PORTS`: per-port request valid.
- `req_ready` out `NUM_PORTS`: per-port grant; a transfer happens when `valid && ready`.
- `req_we` in `NUM_PORTS`: per-port select, 1 = write, 0 = read.
- `req_addr` in `NUM_PORTS`×`ADDR_W`: per-port word address.
- `req_wdata` in `NUM_PORTS`×`DATA_W`: per-port write data.
- `rsp_valid` out `NUM_PORTS`: one-cycle read-data strobe.
- `rsp_rdata` out `NUM_PORTS`×`DATA_W`: read data; valid only while `rsp_valid` is high.
- `ld_en` in 1: preload write enable; has absolute priority.
- `ld_addr` in `ADDR_W`: preload address.
- `ld_data` in `DATA_W`: preload data.
- `busy` out 1: high while any read response is in flight.

## Operation
- At most one storage access per cycle: either a preload write or one granted request.
- **Preload priority:** while `ld_en` is high, every `req_ready` is 0. `mem[ld_addr]` is written at the clock edge.
- **Arbitration:** round-robin with pointer `rr_ptr`. Among the ports with `req_valid` set, grant the first at or after `rr_ptr`, scanning upward with wrap.
  - `req_ready` is combinational. It is one-hot or zero.
  - After a completed handshake on port `g`, `rr_ptr` becomes `(g+1) mod NUM_PORTS`.
  - With no handshake, `rr_ptr` holds.
- **Write handshake:** `mem[req_addr]` ← `req_wdata` at the edge. Writes produce no response.
- **Read handshake:** `mem[req_addr]` is sampled at the handshake edge. The data and the port tag enter a `READ_LAT`-deep response pipeline.
  - When the entry reaches the end, `rsp_valid[tag]` pulses for exactly one cycle.
  - `rsp_rdata[tag]` carries the data during that pulse.
- **No response backpressure:** requesters must accept `rsp_valid` when it arrives.
- **Ordering:** responses return in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- **Addressing:** `ADDR_W` bits with no out-of-range case. The address `2**ADDR_W-1` is an ordinary location.
- `busy` = OR of the pipeline valid bits.
- Storage is not cleared by reset. Contents are undefined until written.

## Timing
- **Reset values:** `rsp_valid`=0, `rsp_rdata`=0, `busy`=0, `rr_ptr`=0, all pipeline valid bits 0.
- `req_ready` stays combinational during reset and follows the arbitration rule with `rr_ptr`=0.
- **Read latency:** handshake on edge N gives `rsp_valid` high in the cycle after edge N+`READ_LAT`−1.
  - For `READ_LAT`=1, the response is visible in the cycle after the handshake.
- **Throughput:** one request per cycle sustained. Back-to-back reads from different ports each get their own response slot.
- **Reset mid-operation:** all in-flight responses are discarded and no `rsp_valid` is emitted for them. Storage keeps its contents.
- **Simultaneous events:**
  - `ld_en` together with `req_valid`: the preload wins. The request stays pending and the requester must hold its signals.
  - `ld_en` to an address whose read is in flight: the in-flight read keeps the old data.
- **Single port:** with `NUM_PORTS`=1, `req_ready[0]` = `!ld_en`.

## Structure
- **Shared `header` package:**
  - Default constants `MEM_DATA_W`=64 and `MEM_ADDR_W`=8.
  - Enum `mem_port_e` with `PORT_IFETCH`=0 and `PORT_DATA`=1.
  - Struct `mem_rsp_slot_t` with fields `{valid, tag, data}` for pipeline entries.
- **Sub-module `rr_arbiter`:** parametrised by `N`. Inputs `req[N]` and `ld_block`, plus the handshake-taken signal. Outputs one-hot `gnt[N]` and holds `rr_ptr` internally.
- Storage array, response pipeline and output demux live in `ext_mem_ctrl`.

## Test plan
1. **Reset:** assert `rst`=0 mid-stream with `READ_LAT`=3 and two reads in flight → `rsp_valid` stays 0 after release, `busy`=0, and a re-read of a preloaded address returns the preloaded value.
2. **Preload then read:** `ld_en` write `ld_addr`=0xFF, `ld_data`=0x0F. Port 1 then reads 0xFF → `rsp_valid[1]` high `READ_LAT` cycles later with `rsp_rdata[1]`=0x0F; `rsp_valid[0]` stays 0.
3. **Fairness:** both ports hold `req_valid` with reads for 6 cycles → grants go 0,1,0,1,0,1, and responses return with matching tags.
4. **Read-after-write:** port 1 writes 0xFD ← 0xFF; next cycle port 0 reads 0xFD → `rsp_rdata[0]`=0xFF.
5. **Preload priority:** `ld_en`=1 for 3 cycles while both ports are valid → `req_ready`=00 throughout, no transfer, and the first grant after `ld_en` drops goes to `rr_ptr`.
6. **Wrap and width:** `ADDR_W`=4, `DATA_W`=32, `NUM_PORTS`=3. Write 0xF ← 0xDEADBEEF and 0x0 ← 0x1 → reads return those values, and the third-port grant wraps `rr_ptr` to 0.

Source files
------------

// File: rtl/ext_mem_ctrl_pkg.sv
// Shared constants and types for the external program/data memory controller.
package ext_mem_ctrl_pkg;

  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MaxTagW    = 3;

  typedef enum logic [MaxTagW-1:0] {
    PORT_IFETCH = 3'd0,
    PORT_DATA   = 3'd1
  } mem_port_e;

  // Response pipeline entry shape at the default word width.
  typedef struct packed {
    logic                  valid;
    logic [MaxTagW-1:0]    tag;
    logic [MEM_DATA_W-1:0] data;
  } mem_rsp_slot_t;

  // Index width that stays at least one bit for a single-entry range.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_mem_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, blocked by preload.
module rr_arbiter
  import ext_mem_ctrl_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         ld_block_i,
  input  logic         take_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PtrW = idx_w(N);

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o   = '0;
    gnt_idx = rr_ptr_q;
    cand    = '0;
    found   = 1'b0;
    if (!ld_block_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        cand = PtrW'((32'(rr_ptr_q) + i) % N);
        if (!found && req_i[cand]) begin
          found        = 1'b1;
          gnt_o[cand]  = 1'b1;
          gnt_idx      = cand;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (take_i) begin
      rr_ptr_d = (gnt_idx == PtrW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/ext_mem_ctrl.sv
// Multi-port memory controller: preload port, round-robin requesters, fixed-latency reads.
module ext_mem_ctrl
  import ext_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = MEM_DATA_W,
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_PORTS-1:0]               req_valid_i,
  output logic [NUM_PORTS-1:0]               req_ready_o,
  input  logic [NUM_PORTS-1:0]               req_we_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   req_wdata_i,
  output logic [NUM_PORTS-1:0]               rsp_valid_o,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]   rsp_rdata_o,
  input  logic                               ld_en_i,
  input  logic [ADDR_W-1:0]                  ld_addr_i,
  input  logic [DATA_W-1:0]                  ld_data_i,
  output logic                               busy_o
);

  localparam int unsigned TagW  = idx_w(NUM_PORTS);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [TagW-1:0]   tag;
    logic [DATA_W-1:0] data;
  } rsp_slot_t;

  logic              hs;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [TagW-1:0]   sel_tag;

  logic [DATA_W-1:0] mem_q [Depth];
  rsp_slot_t         slot_q [READ_LAT];
  rsp_slot_t         slot_d [READ_LAT];
  rsp_slot_t         last;

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_valid_i),
    .ld_block_i (ld_en_i),
    .take_i     (hs),
    .gnt_o      (req_ready_o)
  );

  assign hs = |(req_valid_i & req_ready_o);

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_tag   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (req_ready_o[p]) begin
        sel_we    = req_we_i[p];
        sel_addr  = req_addr_i[p];
        sel_wdata = req_wdata_i[p];
        sel_tag   = TagW'(p);
      end
    end
  end

  // Storage is deliberately not reset so contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end else if (hs && sel_we) begin
      mem_q[sel_addr] <= sel_wdata;
    end
  end

  always_comb begin
    slot_d[0].valid = hs && !sel_we;
    slot_d[0].tag   = sel_tag;
    slot_d[0].data  = mem_q[sel_addr];
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      slot_d[i] = slot_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign last = slot_q[READ_LAT-1];

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    busy_o      = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (last.valid && (last.tag == TagW'(p))) begin
        rsp_valid_o[p] = 1'b1;
        rsp_rdata_o[p] = last.data;
      end
    end
    for (int unsigned i = 0; i < READ_LAT; i++) begin
      busy_o = busy_o | slot_q[i].valid;
    end
  end

endmodule

// File: tb/tb_ext_mem_ctrl.sv
// Directed bench: 2-port READ_LAT=3 controller driven from a vector table, plus a 3-port variant.
module tb_ext_mem_ctrl;
  import ext_mem_ctrl_pkg::*;

  logic clk;
  logic rst_n;

  // DUT A: 64-bit, 256 words, 2 ports, READ_LAT=3
  logic [1:0]        a_valid, a_ready, a_we, a_rsp;
  logic [1:0][7:0]   a_addr;
  logic [1:0][63:0]  a_wdata, a_rdata;
  logic              a_ld_en, a_busy;
  logic [7:0]        a_ld_addr;
  logic [63:0]       a_ld_data;

  // DUT C: 32-bit, 16 words, 3 ports, READ_LAT=1
  logic [2:0]        c_valid, c_ready, c_we, c_rsp;
  logic [2:0][3:0]   c_addr;
  logic [2:0][31:0]  c_wdata, c_rdata;
  logic              c_busy;

  int n_checks = 0;
  int n_err    = 0;

  ext_mem_ctrl #(
    .DATA_W(64), .ADDR_W(8), .NUM_PORTS(2), .READ_LAT(3)
  ) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (a_valid),
    .req_ready_o (a_ready),
    .req_we_i    (a_we),
    .req_addr_i  (a_addr),
    .req_wdata_i (a_wdata),
    .rsp_valid_o (a_rsp),
    .rsp_rdata_o (a_rdata),
    .ld_en_i     (a_ld_en),
    .ld_addr_i   (a_ld_addr),
    .ld_data_i   (a_ld_data),
    .busy_o      (a_busy)
  );

  ext_mem_ctrl #(
    .DATA_W(32), .ADDR_W(4), .NUM_PORTS(3), .READ_LAT(1)
  ) u_dut_c (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (c_valid),
    .req_ready_o (c_ready),
    .req_we_i    (c_we),
    .req_addr_i  (c_addr),
    .req_wdata_i (c_wdata),
    .rsp_valid_o (c_rsp),
    .rsp_rdata_o (c_rdata),
    .ld_en_i     (1'b0),
    .ld_addr_i   (4'h0),
    .ld_data_i   (32'h0),
    .busy_o      (c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [63:0] ld_data;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [63:0] wdata1;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rsp;
    logic [63:0] exp_rdata;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(logic ld, logic [7:0] la, logic [63:0] ldd, logic [1:0] v,
                              logic [1:0] we, logic [7:0] a0, logic [7:0] a1,
                              logic [63:0] wd1, logic [1:0] er, logic [1:0] ersp,
                              logic [63:0] erd, logic eb);
    vec_t r;
    r.ld_en = ld; r.ld_addr = la; r.ld_data = ldd; r.valid = v; r.we = we;
    r.addr0 = a0; r.addr1 = a1; r.wdata1 = wd1;
    r.exp_ready = er; r.exp_rsp = ersp; r.exp_rdata = erd; r.exp_busy = eb;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic ld, input logic [7:0] la, input logic [63:0] ldd,
                         input logic [1:0] v, input logic [1:0] we, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [63:0] wd1);
    a_ld_en = ld; a_ld_addr = la; a_ld_data = ldd;
    a_valid = v; a_we = we; a_addr[0] = a0; a_addr[1] = a1;
    a_wdata[0] = 64'h5555_5555_5555_5555; a_wdata[1] = wd1;
  endtask

  task automatic drive_c(input logic [2:0] v, input logic [2:0] we,
                         input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [31:0] wd0, input logic [31:0] wd1);
    c_valid = v; c_we = we;
    c_addr[0] = a0; c_addr[1] = a1; c_addr[2] = a2;
    c_wdata[0] = wd0; c_wdata[1] = wd1; c_wdata[2] = 32'h0;
  endtask

  initial begin
    //          ld  ld_addr ld_data    v      we     a0     a1     wd1    ready  rsp    rdata  busy
    vecs[0]  = mk(1, 8'hFF, 64'h0F, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b00, 2'b00, 64'h0,  0);
    vecs[1]  = mk(1, 8'h10, 64'hA0, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b00, 2'b00, 64'h0,  0);
    vecs[2]  = mk(1, 8'h11, 64'hA1, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b00, 2'b00, 64'h0,  0);
    vecs[3]  = mk(0, 8'h00, 64'h00, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b01, 2'b00, 64'h0,  0);
    vecs[4]  = mk(0, 8'h00, 64'h00, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b10, 2'b00, 64'h0,  1);
    vecs[5]  = mk(0, 8'h00, 64'h00, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b01, 2'b00, 64'h0,  1);
    vecs[6]  = mk(0, 8'h00, 64'h00, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b10, 2'b01, 64'hA0, 1);
    vecs[7]  = mk(0, 8'h00, 64'h00, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b01, 2'b10, 64'hA1, 1);
    vecs[8]  = mk(0, 8'h00, 64'h00, 2'b11, 2'b00, 8'h10, 8'h11, 64'h0, 2'b10, 2'b01, 64'hA0, 1);
    vecs[9]  = mk(0, 8'h00, 64'h00, 2'b10, 2'b00, 8'h00, 8'hFF, 64'h0, 2'b10, 2'b10, 64'hA1, 1);
    vecs[10] = mk(0, 8'h00, 64'h00, 2'b10, 2'b10, 8'h00, 8'hFD, 64'hFF, 2'b10, 2'b01, 64'hA0, 1);
    vecs[11] = mk(0, 8'h00, 64'h00, 2'b01, 2'b00, 8'hFD, 8'h00, 64'h0, 2'b01, 2'b10, 64'hA1, 1);
    vecs[12] = mk(0, 8'h00, 64'h00, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 2'b00, 2'b10, 64'h0F, 1);
    vecs[13] = mk(0, 8'h00, 64'h00, 2'b01, 2'b00, 8'h10, 8'h00, 64'h0, 2'b01, 2'b00, 64'h0,  1);
    vecs[14] = mk(1, 8'h10, 64'hB0, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 2'b00, 2'b01, 64'hFF, 1);
    vecs[15] = mk(0, 8'h00, 64'h00, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 2'b00, 2'b00, 64'h0,  1);
    vecs[16] = mk(0, 8'h00, 64'h00, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 2'b00, 2'b01, 64'hA0, 1);
    vecs[17] = mk(0, 8'h00, 64'h00, 2'b01, 2'b00, 8'h10, 8'h00, 64'h0, 2'b01, 2'b00, 64'h0,  0);
    vecs[18] = mk(0, 8'h00, 64'h00, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 2'b00, 2'b00, 64'h0,  1);
    vecs[19] = mk(0, 8'h00, 64'h00, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 2'b00, 2'b00, 64'h0,  1);
    vecs[20] = mk(0, 8'h00, 64'h00, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 2'b00, 2'b01, 64'hB0, 1);
    vecs[21] = mk(0, 8'h00, 64'h00, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 2'b00, 2'b00, 64'h0,  0);

    // Reset state; arbitration stays live during reset with rr_ptr=0.
    rst_n = 1'b0;
    drive_a(0, 8'h0, 64'h0, 2'b11, 2'b00, 8'h0, 8'h0, 64'h0);
    drive_c(3'b000, 3'b000, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    #2;
    check("reset a_ready", 64'(a_ready), 64'(2'b01));
    check("reset a_rsp", 64'(a_rsp), 64'h0);
    check("reset a_rdata1", a_rdata[1], 64'h0);
    check("reset a_busy", 64'(a_busy), 64'h0);
    check("reset c_rsp", 64'(c_rsp), 64'h0);
    check("reset c_busy", 64'(c_busy), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 2'b00;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive_a(vecs[i].ld_en, vecs[i].ld_addr, vecs[i].ld_data, vecs[i].valid, vecs[i].we,
              vecs[i].addr0, vecs[i].addr1, vecs[i].wdata1);
      #1;
      check($sformatf("row%0d ready", i), 64'(a_ready), 64'(vecs[i].exp_ready));
      check($sformatf("row%0d rsp_valid", i), 64'(a_rsp), 64'(vecs[i].exp_rsp));
      check($sformatf("row%0d busy", i), 64'(a_busy), 64'(vecs[i].exp_busy));
      if (vecs[i].exp_rsp[0]) check($sformatf("row%0d rdata0", i), a_rdata[0], vecs[i].exp_rdata);
      if (vecs[i].exp_rsp[1]) check($sformatf("row%0d rdata1", i), a_rdata[1], vecs[i].exp_rdata);
    end

    // Reset with two reads in flight: nothing may emerge afterwards, storage survives.
    @(negedge clk);
    drive_a(0, 8'h0, 64'h0, 2'b11, 2'b00, 8'hFF, 8'h11, 64'h0);
    #1;
    check("mid ready p1", 64'(a_ready), 64'(2'b10));
    @(negedge clk);
    #1;
    check("mid ready p0", 64'(a_ready), 64'(2'b01));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("in-reset busy", 64'(a_busy), 64'h0);
    check("in-reset rsp", 64'(a_rsp), 64'h0);
    check("in-reset ready", 64'(a_ready), 64'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(0, 8'h0, 64'h0, 2'b00, 2'b00, 8'h0, 8'h0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("post-reset rsp c%0d", i), 64'(a_rsp), 64'h0);
      check($sformatf("post-reset busy c%0d", i), 64'(a_busy), 64'h0);
      @(negedge clk);
    end
    drive_a(0, 8'h0, 64'h0, 2'b10, 2'b00, 8'h0, 8'hFF, 64'h0);
    #1;
    check("reread ready", 64'(a_ready), 64'(2'b10));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive_a(0, 8'h0, 64'h0, 2'b00, 2'b00, 8'h0, 8'h0, 64'h0);
      #1;
      check($sformatf("reread rsp +%0d", i), 64'(a_rsp), (i == 3) ? 64'(2'b10) : 64'h0);
    end
    check("reread rdata1", a_rdata[1], 64'h0F);

    // Narrow 3-port variant: top address, address 0, and pointer wrap from port 2.
    @(negedge clk);
    drive_c(3'b001, 3'b001, 4'hF, 4'h0, 4'h0, 32'hDEADBEEF, 32'h0);
    #1;
    check("c write F ready", 64'(c_ready), 64'(3'b001));
    @(negedge clk);
    drive_c(3'b010, 3'b010, 4'h0, 4'h0, 4'h0, 32'h0, 32'h1);
    #1;
    check("c write 0 ready", 64'(c_ready), 64'(3'b010));
    @(negedge clk);
    drive_c(3'b111, 3'b000, 4'hF, 4'h0, 4'hF, 32'h0, 32'h0);
    #1;
    check("c grant p2", 64'(c_ready), 64'(3'b100));
    @(negedge clk);
    #1;
    check("c wrap grant p0", 64'(c_ready), 64'(3'b001));
    check("c rsp p2", 64'(c_rsp), 64'(3'b100));
    check("c rdata2", 64'(c_rdata[2]), 64'hDEADBEEF);
    @(negedge clk);
    drive_c(3'b010, 3'b000, 4'hF, 4'h0, 4'hF, 32'h0, 32'h0);
    #1;
    check("c grant p1", 64'(c_ready), 64'(3'b010));
    check("c rsp p0", 64'(c_rsp), 64'(3'b001));
    check("c rdata0", 64'(c_rdata[0]), 64'hDEADBEEF);
    @(negedge clk);
    drive_c(3'b000, 3'b000, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    check("c rsp p1", 64'(c_rsp), 64'(3'b010));
    check("c rdata1", 64'(c_rdata[1]), 64'h1);
    @(negedge clk);
    #1;
    check("c idle busy", 64'(c_busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
